freq_period_meter: RTL and testbench

- Receive-side counterpart of the team's clock dividers.
- Takes a slow, divided or external square wave on `sig_in` and measures its period and high time in `clk` cycles.
- Reports whether the period is an exact power-of-two ratio (and which one), whether duty is 50 %, and whether the signal has stopped.
- Used to self-check divider outputs on-chip and to detect lost clocks.

---
 rtl/freq_period_meter.sv | 196 +++++++++++++++++++
 tb/tb_freq_period_meter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_period_meter.sv
// freq_period_meter: measures period and high time of a slow square wave in clk cycles.
// It flags power-of-two periods (with log2), 50 % duty, and loss of signal.
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-low reset
//   sig_in     - signal under measurement, asynchronous to clk
//   meas_en    - measurement enable; low returns to IDLE
//   period     - cycles between the last two rising edges
//   high_time  - cycles from a rising edge to the following falling edge
//   meas_valid - one-cycle pulse when period/high_time update
//   ratio_log2 - log2(period) when is_pow2, else 0
//   is_pow2    - period is a power of two and >= 2
//   duty50     - 2*high_time == period
//   no_signal  - TIMEOUT cycles elapsed without a rising edge (sticky)
module freq_period_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic [4:0]       ratio_log2,
  output logic             is_pow2,
  output logic             duty50,
  output logic             no_signal
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C     = CNT_W'(2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  // Synchronizer chain plus one history flop for edge detection
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out_c;
  logic                   rise_c;
  logic                   fall_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out_c = sync_q[SYNC_STAGES-1];
  assign rise_c     = sync_out_c & ~prev_q;
  assign fall_c     = ~sync_out_c & prev_q;

  // Measurement state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic             hi_seen_q, hi_seen_d;

  logic [CNT_W-1:0] period_d;
  logic [CNT_W-1:0] high_time_d;
  logic             meas_valid_d;
  logic [4:0]       ratio_log2_d;
  logic             is_pow2_d;
  logic             duty50_d;
  logic             no_signal_d;

  // Classification of the period about to be latched (the live counter value)
  logic             pow2_c;
  logic [4:0]       log2_c;
  logic             duty_c;
  logic             timeout_c;

  always_comb begin
    pow2_c = (cnt_q >= TWO_C) && ((cnt_q & (cnt_q - ONE_C)) == '0);
    log2_c = 5'd0;
    for (int unsigned i = 0; i < CNT_W; i++) begin
      if (cnt_q[i]) log2_c = 5'(i);
    end
    // One extra bit so that 2*hi_cap cannot overflow the compare
    duty_c    = ({hi_cap_q, 1'b0} == {1'b0, cnt_q});
    timeout_c = (cnt_q == TIMEOUT_C);
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_cap_d     = hi_cap_q;
    hi_seen_d    = hi_seen_q;
    period_d     = period;
    high_time_d  = high_time;
    meas_valid_d = 1'b0;
    ratio_log2_d = ratio_log2;
    is_pow2_d    = is_pow2;
    duty50_d     = duty50;
    no_signal_d  = no_signal;

    if (!meas_en) begin
      // Enable dominates any coincident edge
      state_d     = IDLE;
      cnt_d       = '0;
      hi_cap_d    = '0;
      hi_seen_d   = 1'b0;
      no_signal_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
        end
        ARM: begin
          if (rise_c) begin
            // First edge only starts the period; nothing to report yet
            state_d     = MEASURE;
            cnt_d       = ONE_C;
            hi_seen_d   = 1'b0;
            no_signal_d = 1'b0;
          end else if (timeout_c) begin
            no_signal_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        MEASURE: begin
          // A rise coinciding with timeout still completes the measurement
          if (rise_c) begin
            period_d     = cnt_q;
            high_time_d  = hi_cap_q;
            is_pow2_d    = pow2_c;
            ratio_log2_d = pow2_c ? log2_c : 5'd0;
            duty50_d     = duty_c;
            meas_valid_d = 1'b1;
            cnt_d        = ONE_C;
            hi_seen_d    = 1'b0;
          end else if (timeout_c) begin
            no_signal_d = 1'b1;
            state_d     = ARM;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + ONE_C;
            if (fall_c && !hi_seen_q) begin
              hi_cap_d  = cnt_q;
              hi_seen_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_cap_q   <= '0;
      hi_seen_q  <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      ratio_log2 <= 5'd0;
      is_pow2    <= 1'b0;
      duty50     <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_cap_q   <= hi_cap_d;
      hi_seen_q  <= hi_seen_d;
      period     <= period_d;
      high_time  <= high_time_d;
      meas_valid <= meas_valid_d;
      ratio_log2 <= ratio_log2_d;
      is_pow2    <= is_pow2_d;
      duty50     <= duty50_d;
      no_signal  <= no_signal_d;
    end
  end

endmodule

// File: tb/tb_freq_period_meter.sv
// Testbench for freq_period_meter: directed table, hand-written corner sequences,
// and random waveforms, all checked every cycle against a timestamp-based model.
module tb_freq_period_meter;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TO    = 64;
  localparam int unsigned SYNC  = 2;

  logic             clk;
  logic             reset;
  logic             sig_in;
  logic             meas_en;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic [4:0]       ratio_log2;
  logic             is_pow2;
  logic             duty50;
  logic             no_signal;

  freq_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .meas_en    (meas_en),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .ratio_log2 (ratio_log2),
    .is_pow2    (is_pow2),
    .duty50     (duty50),
    .no_signal  (no_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model (event timestamps) ----------------
  bit hq[$];
  int ms;       // 0 idle, 1 waiting first rise, 2 measuring
  int mj;       // edge index
  int mref;     // edge index at which the live count would read 0
  bit mhs;
  int mhc;
  int e_per, e_hi, e_log;
  bit e_valid, e_pow2, e_duty, e_nos;

  task automatic mreset();
    hq = {};
    for (int i = 0; i < int'(SYNC) + 1; i++) hq.push_back(1'b0);
    ms = 0; mj = 0; mref = 0; mhs = 0; mhc = 0;
    e_per = 0; e_hi = 0; e_log = 0;
    e_valid = 0; e_pow2 = 0; e_duty = 0; e_nos = 0;
  endtask

  task automatic model_edge(input bit x, input bit m);
    bit pv, sy, r, f, dropped;
    int p;
    pv = hq[0];
    sy = hq[1];
    hq.push_back(x);
    dropped = hq.pop_front();
    r = sy & ~pv;
    f = ~sy & pv;
    mj++;
    e_valid = 0;
    if (!m) begin
      ms = 0; e_nos = 0; mhs = 0;
    end else if (ms == 0) begin
      ms = 1; mref = mj + 1;
    end else if (ms == 1) begin
      if (r) begin
        ms = 2; mref = mj; mhs = 0; e_nos = 0;
      end else if (mj - mref == int'(TO)) begin
        e_nos = 1; mref = mj + 1;
      end
    end else begin
      if (r) begin
        p = mj - mref;
        e_per = p; e_hi = mhc; e_valid = 1;
        e_pow2 = (p >= 2) && ((1 << $clog2(p)) == p);
        e_log = e_pow2 ? $clog2(p) : 0;
        e_duty = (2 * mhc == p);
        mref = mj; mhs = 0;
      end else if (mj - mref == int'(TO)) begin
        e_nos = 1; ms = 1; mref = mj + 1;
      end else if (f && !mhs) begin
        mhc = mj - mref; mhs = 1;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  int nval = 0;
  int since = 0;
  int last_per = 0, last_hi = 0, last_log = 0;
  bit last_pow2 = 0, last_duty = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic [2*CNT_W+8:0] act, exp;
    act = {period, high_time, meas_valid, ratio_log2, is_pow2, duty50, no_signal};
    exp = {CNT_W'(e_per), CNT_W'(e_hi), e_valid, 5'(e_log), e_pow2, e_duty, e_nos};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL model edge %0d: got per=%0d hi=%0d v=%0b l2=%0d p2=%0b d50=%0b ns=%0b expected per=%0d hi=%0d v=%0b l2=%0d p2=%0b d50=%0b ns=%0b",
               mj, period, high_time, meas_valid, ratio_log2, is_pow2, duty50, no_signal,
               e_per, e_hi, e_valid, e_log, e_pow2, e_duty, e_nos);
    end
  endtask

  task automatic step(input bit x, input bit m);
    sig_in  = x;
    meas_en = m;
    @(posedge clk);
    model_edge(x, m);
    #1;
    check_cycle();
    if (meas_valid) begin
      nval++; since = 0;
      last_per = int'(period); last_hi = int'(high_time); last_log = int'(ratio_log2);
      last_pow2 = is_pow2; last_duty = duty50;
    end else begin
      since++;
    end
  endtask

  int gph = 0;
  task automatic run_wave(input int hi, input int lo, input int n, input bit m);
    for (int i = 0; i < n; i++) begin
      step(((gph % (hi + lo)) < hi), m);
      gph++;
    end
  endtask

  typedef struct {
    int hi; int lo; int reps;
    int e_per; int e_hi; int e_pow2; int e_log; int e_duty;
  } vec_t;
  vec_t tbl[8];

  initial begin
    bit found;
    int hi, lo, sel;
    bit m;

    tbl[0] = '{4, 4, 5, 8, 4, 1, 3, 1};
    tbl[1] = '{3, 7, 5, 10, 3, 0, 0, 0};
    tbl[2] = '{2, 2, 6, 4, 2, 1, 2, 1};
    tbl[3] = '{5, 11, 5, 16, 5, 1, 4, 0};
    tbl[4] = '{6, 6, 5, 12, 6, 0, 0, 1};
    tbl[5] = '{1, 1, 8, 2, 1, 1, 1, 1};
    tbl[6] = '{20, 44, 5, 64, 20, 1, 6, 0};
    tbl[7] = '{1, 2, 6, 3, 1, 0, 0, 0};

    reset = 1'b1; sig_in = 1'b0; meas_en = 1'b0;
    mreset();
    #2 reset = 1'b0;
    #1;
    chk("reset_period", int'(period), 0);
    chk("reset_high", int'(high_time), 0);
    chk("reset_valid", int'(meas_valid), 0);
    chk("reset_nosig", int'(no_signal), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Disabled: toggling input must leave everything at zero
    gph = 0; nval = 0;
    run_wave(1, 1, 20, 1'b0);
    chk("idle_pulses", nval, 0);
    chk("idle_period", int'(period), 0);
    chk("idle_pow2", int'(is_pow2), 0);

    // Directed waveforms
    for (int t = 0; t < 8; t++) begin
      gph = 0; nval = 0;
      run_wave(tbl[t].hi, tbl[t].lo, tbl[t].reps * (tbl[t].hi + tbl[t].lo), 1'b1);
      chk($sformatf("tbl%0d_pulses", t), int'(nval >= tbl[t].reps - 2), 1);
      chk($sformatf("tbl%0d_period", t), last_per, tbl[t].e_per);
      chk($sformatf("tbl%0d_high", t), last_hi, tbl[t].e_hi);
      chk($sformatf("tbl%0d_pow2", t), int'(last_pow2), tbl[t].e_pow2);
      chk($sformatf("tbl%0d_log2", t), last_log, tbl[t].e_log);
      chk($sformatf("tbl%0d_duty", t), int'(last_duty), tbl[t].e_duty);
      chk($sformatf("tbl%0d_nosig", t), int'(no_signal), 0);
    end

    // Timeout: clk/4 then held low
    gph = 0;
    run_wave(2, 2, 40, 1'b1);
    found = 0;
    for (int k = 0; k < 200; k++) begin
      step(1'b0, 1'b1);
      if (no_signal) begin found = 1; break; end
    end
    chk("timeout_seen", int'(found), 1);
    chk("timeout_dist", since, int'(TO));
    chk("timeout_period_hold", int'(period), 4);
    // Restart with clk/2: first rise clears no_signal without a pulse
    gph = 0; found = 0;
    for (int k = 0; k < 12; k++) begin
      step(((gph % 2) < 1), 1'b1); gph++;
      if (!no_signal) begin found = 1; break; end
    end
    chk("nosig_cleared", int'(found), 1);
    chk("nosig_clear_no_valid", int'(meas_valid), 0);
    run_wave(1, 1, 8, 1'b1);
    chk("restart_period", last_per, 2);
    chk("restart_log2", last_log, 1);

    // Enable dropped mid-period
    gph = 0;
    run_wave(4, 4, 22, 1'b1);
    run_wave(4, 4, 5, 1'b0);
    nval = 0;
    run_wave(4, 4, 8, 1'b1);
    chk("reenable_no_early_pulse", nval, 0);
    run_wave(4, 4, 16, 1'b1);
    chk("reenable_pulse", int'(nval >= 1), 1);
    chk("reenable_period", last_per, 8);

    // Asynchronous reset in the middle of a measurement
    gph = 0;
    run_wave(4, 4, 30, 1'b1);
    chk("pre_reset_period", int'(period), 8);
    #2 reset = 1'b0;
    #1;
    chk("async_period", int'(period), 0);
    chk("async_high", int'(high_time), 0);
    chk("async_pow2", int'(is_pow2), 0);
    chk("async_log2", int'(ratio_log2), 0);
    chk("async_duty", int'(duty50), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    mreset();
    gph = 0; nval = 0;
    run_wave(4, 4, 40, 1'b1);
    chk("post_reset_pulses", int'(nval >= 2), 1);
    chk("post_reset_period", last_per, 8);

    // Random waveforms, enable drops, long gaps and exact-timeout periods
    for (int seg = 0; seg < 150; seg++) begin
      hi = int'($urandom_range(1, 12));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      lo = int'($urandom_range(50, 90));
      else if (sel == 1) lo = int'(TO) - hi;
      else               lo = int'($urandom_range(1, 12));
      for (int c = 0; c < hi + lo; c++) begin
        m = !((seg % 13 == 7) && c >= 1 && c < 4);
        step((c < hi), m);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
